// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and sizes for the LED bank scheduler
package led_sched_pkg;
  localparam int NUM_REQ = 4;
  localparam int LED_W   = 9;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } led_sched_state_t;

  typedef logic [NUM_REQ-1:0][LED_W-1:0] pattern_bank_t;
endpackage

// File: rtl/led_bank_scheduler_if.sv
// rtl/led_bank_scheduler_if.sv - request/pattern inputs and LED/grant outputs of the scheduler
interface led_bank_scheduler_if;
  logic [led_sched_pkg::NUM_REQ-1:0] REQ_I;
  led_sched_pkg::pattern_bank_t      PATTERN_I;
  logic [led_sched_pkg::LED_W-1:0]   LED_GREEN_O;
  logic [led_sched_pkg::NUM_REQ-1:0] GRANT_O;
  logic                              BUSY_O;

  modport master (output REQ_I, output PATTERN_I, input LED_GREEN_O, input GRANT_O, input BUSY_O);
  modport slave  (input REQ_I, input PATTERN_I, output LED_GREEN_O, output GRANT_O, output BUSY_O);
endinterface

// File: rtl/led_bank_scheduler_rr_arbiter.sv
// rtl/led_bank_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module rr_arbiter
  import led_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit to ptr_i wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
    grant_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/led_bank_scheduler.sv
// rtl/led_bank_scheduler.sv - time-shares the green LED bank among four round-robin sources
module led_bank_scheduler
  import led_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                 CLOCK_50_I,
  input  logic                 RESET_I,
  led_bank_scheduler_if.slave  bus
);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  led_sched_state_t   state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               start_grant;

  rr_arbiter u_arb (
    .req_i   (bus.REQ_I),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    start_grant = 1'b0;

    case (state_q)
      IDLE: start_grant = arb_valid;
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST || !bus.REQ_I[idx_q]) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (arb_valid) start_grant = 1'b1;
          else           state_d     = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_grant) begin
      state_d    = HOLD;
      idx_d      = arb_idx;
      ptr_d      = arb_idx + IDX_W'(1);
      hold_cnt_d = '0;
    end

    // Outputs come from next state/grantee so LEDs and grant switch on the same edge.
    grant_d = '0;
    led_d   = '0;
    if (state_d == HOLD) begin
      grant_d = start_grant ? arb_grant : grant_q;
      led_d   = bus.PATTERN_I[idx_d];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      grant_q    <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      grant_q    <= grant_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.GRANT_O     = grant_q;
  assign bus.LED_GREEN_O = led_q;
  assign bus.BUSY_O      = busy_q;
endmodule

// File: tb/tb_led_bank_scheduler.sv
// tb/tb_led_bank_scheduler.sv - scoreboard bench for led_bank_scheduler with HOLD=4, GAP=2
module tb_led_bank_scheduler;
  import led_sched_pkg::*;

  typedef struct packed {
    logic [NUM_REQ-1:0] grant;
    logic [LED_W-1:0]   led;
    logic               busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  string phase = "init";
  pattern_bank_t pat;
  exp_t sb[$];

  led_bank_scheduler_if bus ();

  led_bank_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .CLOCK_50_I (clk),
    .RESET_I    (rst),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
  task automatic cyc(input logic [3:0] req, input logic [3:0] eg, input logic [8:0] el, input logic eb);
    exp_t e;
    bus.REQ_I     = req;
    bus.PATTERN_I = pat;
    sb.push_back('{grant: eg, led: el, busy: eb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("grant", 32'(bus.GRANT_O), 32'(e.grant));
    check("led",   32'(bus.LED_GREEN_O), 32'(e.led));
    check("busy",  32'(bus.BUSY_O), 32'(e.busy));
  endtask

  task automatic hold(input int src, input int n, input logic [3:0] req);
    for (int i = 0; i < n; i++) cyc(req, 4'(1) << src, pat[src], 1'b1);
  endtask

  task automatic gap(input int n, input logic [3:0] req);
    for (int i = 0; i < n; i++) cyc(req, 4'b0, 9'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0, 4'b0, 9'h0, 1'b0);
  endtask

  task automatic reset_dut(input logic [3:0] req);
    rst = 1'b1;
    cyc(req, 4'b0, 9'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) pat[i] = 9'h100 >> i;
    bus.REQ_I     = '0;
    bus.PATTERN_I = pat;

    phase = "reset_idle";
    reset_dut(4'b1111);
    idle(10);

    phase = "single_src2";
    reset_dut(4'b0000);
    hold(2, 4, 4'b0100);
    gap(2, 4'b0100);
    hold(2, 1, 4'b0100);
    gap(2, 4'b0000);
    idle(2);

    phase = "round_robin";
    reset_dut(4'b0000);
    hold(0, 4, 4'b1111); gap(2, 4'b1111);
    hold(1, 4, 4'b1111); gap(2, 4'b1111);
    hold(2, 4, 4'b1111); gap(2, 4'b1111);
    hold(3, 4, 4'b1111); gap(2, 4'b1111);
    hold(0, 4, 4'b1111);
    gap(2, 4'b0000);
    idle(1);

    phase = "early_release";
    reset_dut(4'b0000);
    hold(1, 2, 4'b0010);
    gap(2, 4'b0000);
    idle(2);

    phase = "no_preempt";
    reset_dut(4'b0000);
    hold(3, 2, 4'b1000);
    hold(3, 1, 4'b1001);
    pat[3] = 9'h1ab;
    hold(3, 1, 4'b1001);
    pat[3] = 9'h020;
    gap(2, 4'b1001);
    hold(0, 2, 4'b1001);
    gap(2, 4'b0000);
    idle(1);

    phase = "reset_mid_hold";
    reset_dut(4'b0000);
    hold(1, 2, 4'b0010);
    reset_dut(4'b1010);
    hold(1, 4, 4'b1010);
    gap(2, 4'b1010);
    hold(3, 1, 4'b1010);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard left %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
